// File: rtl/dig_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver: latches a 32-bit value
// and multiplexes it as hex digits onto active-low digit-select and segment pins.
module dig_scan_driver #(
  parameter int SCAN_DIV = 20000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk_from_cpu,
  input  logic        rst_from_cpu,
  input  logic        wen_dig,
  input  logic [31:0] wdata_dig,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [31:0]   data_reg;
  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [4:0]    nib_sh;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    dig_next;
  logic [7:0]    seg_next;

  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Digit i is a leading zero when every nibble from i upward is zero; digit 0 always shows.
  always_comb begin
    nib_sh   = {idx, 2'b00};
    nib      = data_reg[nib_sh +: 4];
    blank    = (BLANK_LZ != 0) && (idx != 3'd0) && ((data_reg >> nib_sh) == '0);
    seg_next = blank ? 8'hFF : decode(nib);
    dig_next = ~(8'b1 << idx);
  end

  always_ff @(posedge clk_from_cpu) begin
    if (rst_from_cpu) begin
      data_reg <= '0;
      div_cnt  <= '0;
      idx      <= '0;
      dig_en   <= '1;
      seg      <= '1;
    end else begin
      if (wen_dig)
        data_reg <= wdata_dig;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      dig_en <= dig_next;
      seg    <= seg_next;
    end
  end

endmodule

// File: tb/tb_dig_scan_driver.sv
// Bench for dig_scan_driver: three instances (div 4 no blanking, div 4 blanking,
// div 1 blanking) share stimulus; expectations are queued per edge and checked after it.
module tb_dig_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [31:0] wdata;
  logic [7:0]  dig_a, seg_a, dig_b, seg_b, dig_c, seg_c;

  always #5 clk = ~clk;

  dig_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(0)) u_a (
    .clk_from_cpu(clk), .rst_from_cpu(rst), .wen_dig(wen), .wdata_dig(wdata),
    .dig_en(dig_a), .seg(seg_a));
  dig_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1)) u_b (
    .clk_from_cpu(clk), .rst_from_cpu(rst), .wen_dig(wen), .wdata_dig(wdata),
    .dig_en(dig_b), .seg(seg_b));
  dig_scan_driver #(.SCAN_DIV(1), .BLANK_LZ(1)) u_c (
    .clk_from_cpu(clk), .rst_from_cpu(rst), .wen_dig(wen), .wdata_dig(wdata),
    .dig_en(dig_c), .seg(seg_c));

  typedef struct {
    string      tag;
    int         unit;
    logic [7:0] dig;
    logic [7:0] seg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [31:0] vis = '0;

  localparam logic [7:0] TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam int DIVS [3] = '{4, 4, 1};
  localparam bit BLNK [3] = '{1'b0, 1'b1, 1'b1};

  function automatic int shown_digit(input int div, input int kk);
    return ((kk - 1) / div) % 8;
  endfunction

  function automatic logic [7:0] exp_dig(input int div, input int kk);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << shown_digit(div, kk));
  endfunction

  function automatic logic [7:0] exp_seg(input int div, input bit blk, input int kk,
                                         input logic [31:0] v);
    int          d;
    logic [31:0] upper;
    d     = shown_digit(div, kk);
    upper = v >> (4 * d);
    if (blk && d != 0 && upper == 32'd0)
      return 8'hFF;
    return TBL[upper[3:0]];
  endfunction

  function automatic logic [7:0] obs_dig(input int u);
    case (u)
      0:       return dig_a;
      1:       return dig_b;
      default: return dig_c;
    endcase
  endfunction

  function automatic logic [7:0] obs_seg(input int u);
    case (u)
      0:       return seg_a;
      1:       return seg_b;
      default: return seg_c;
    endcase
  endfunction

  task automatic tick(input logic r, input logic w, input logic [31:0] d, input string tag);
    exp_t e;
    rst   = r;
    wen   = w;
    wdata = d;
    if (!r) k++;
    for (int u = 0; u < 3; u++) begin
      e.tag  = tag;
      e.unit = u;
      e.dig  = r ? 8'hFF : exp_dig(DIVS[u], k);
      e.seg  = r ? 8'hFF : exp_seg(DIVS[u], BLNK[u], k, vis);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      vis = '0;
      k   = 0;
    end else if (w) begin
      vis = d;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs_dig(e.unit) === e.dig) else begin
        errors++;
        $error("FAIL %s unit%0d k=%0d dig_en got %h want %h", e.tag, e.unit, k, obs_dig(e.unit), e.dig);
      end
      checks++;
      assert (obs_seg(e.unit) === e.seg) else begin
        errors++;
        $error("FAIL %s unit%0d k=%0d seg got %h want %h", e.tag, e.unit, k, obs_seg(e.unit), e.seg);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'hDEAD_BEEF, tag);
  endtask

  initial begin
    rst   = 1'b1;
    wen   = 1'b0;
    wdata = '0;
    tick(1'b1, 1'b0, '0, "reset");
    tick(1'b1, 1'b1, 32'h1234_5678, "reset_wr_ignored");

    run(40, "zero_scan");

    tick(1'b0, 1'b1, 32'h89AB_CDEF, "wr_89abcdef");
    run(34, "scan_89abcdef");

    tick(1'b0, 1'b1, 32'h0000_0120, "wr_120");
    run(33, "scan_120");
    tick(1'b0, 1'b1, 32'h0000_0000, "wr_0");
    run(33, "scan_0");

    while ((k % 32) != 31) tick(1'b0, 1'b0, '0, "align_wrap");
    tick(1'b0, 1'b1, 32'h0000_0005, "wr_5_on_wrap");
    tick(1'b0, 1'b0, '0, "show_5");

    tick(1'b0, 1'b1, 32'h0000_0001, "wr_1");
    tick(1'b0, 1'b1, 32'h0000_0002, "wr_2");
    run(34, "last_write_wins");

    for (int i = 0; i < 34; i++) tick(1'b0, 1'b0, 32'hFFFF_FFFF, "wen_low_ignored");

    tick(1'b0, 1'b1, 32'h1234_5678, "wr_12345678");
    while (((k / 4) % 8) != 5) tick(1'b0, 1'b0, '0, "align_idx5");
    tick(1'b1, 1'b0, '0, "reset_mid_scan");
    run(40, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
